// File: rtl/execute_muldiv.sv
// RV32M execute-stage unit: forwarded operand capture, iterative shift-add multiply
// and restoring divide, with a hazard-unit stall until the result is presented.
module execute_muldiv #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  validE_i,
    input  logic                  MulDivE_i,
    input  logic [2:0]            MulDivOpE_i,
    input  logic [DATA_WIDTH-1:0] RD1E_i,
    input  logic [DATA_WIDTH-1:0] RD2E_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [1:0]            ForwardAEctrl_i,
    input  logic [1:0]            ForwardBEctrl_i,
    output logic                  StallE_o,
    output logic                  DoneE_o,
    output logic [DATA_WIDTH-1:0] MDResultE_o
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned N     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic                 r_neg_a;
    logic                 r_neg_res;
    logic [W-1:0]         r_opnd;
    logic [2*W-1:0]       r_acc;
    logic [W-1:0]         r_result;

    logic [W-1:0]         w_fwd_a;
    logic [W-1:0]         w_fwd_b;
    logic                 w_sgn_a_en;
    logic                 w_sgn_b_en;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [W-1:0]         w_mag_a;
    logic [W-1:0]         w_mag_b;
    logic                 w_start;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic                 w_special;
    logic [W-1:0]         w_special_res;
    logic [2*W-1:0]       w_acc_nxt;
    logic [W:0]           w_sum;
    logic [W:0]           w_rem_trial;
    logic [2*W-1:0]       w_prod;
    logic [W-1:0]         w_quo;
    logic [W-1:0]         w_rem;
    logic [W-1:0]         w_mul_res;
    logic [W-1:0]         w_div_res;
    logic [W-1:0]         w_final;

    // Operand forwarding muxes
    always_comb begin
        case (ForwardAEctrl_i)
            2'b01:   w_fwd_a = ResultW_i;
            2'b10:   w_fwd_a = ALUResultM_i;
            default: w_fwd_a = RD1E_i;
        endcase
        case (ForwardBEctrl_i)
            2'b01:   w_fwd_b = ResultW_i;
            2'b10:   w_fwd_b = ALUResultM_i;
            default: w_fwd_b = RD2E_i;
        endcase
    end

    assign w_sgn_a_en = (MulDivOpE_i == 3'b001) || (MulDivOpE_i == 3'b010) ||
                        (MulDivOpE_i == 3'b100) || (MulDivOpE_i == 3'b110);
    assign w_sgn_b_en = (MulDivOpE_i == 3'b001) || (MulDivOpE_i == 3'b100) ||
                        (MulDivOpE_i == 3'b110);
    assign w_neg_a    = w_sgn_a_en & w_fwd_a[W-1];
    assign w_neg_b    = w_sgn_b_en & w_fwd_b[W-1];
    assign w_mag_a    = w_neg_a ? (~w_fwd_a + W'(1)) : w_fwd_a;
    assign w_mag_b    = w_neg_b ? (~w_fwd_b + W'(1)) : w_fwd_b;

    assign w_start    = (r_state == IDLE) & validE_i & MulDivE_i & ~flush_i;
    assign w_div_zero = MulDivOpE_i[2] & (w_fwd_b == '0);
    assign w_ovf      = MulDivOpE_i[2] & ~MulDivOpE_i[0] &
                        (w_fwd_a == {1'b1, {(W-1){1'b0}}}) & (w_fwd_b == '1);
    assign w_special  = w_div_zero | w_ovf;

    // Divide-by-zero takes priority; overflow only reachable with a -1 divisor
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = MulDivOpE_i[1] ? w_fwd_a : '1;
        end else if (w_ovf) begin
            w_special_res = MulDivOpE_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        end
    end

    // BITS_PER_CYCLE unrolled steps of shift-add multiply or restoring divide
    always_comb begin
        w_acc_nxt   = r_acc;
        w_sum       = '0;
        w_rem_trial = '0;
        for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
            if (r_op[2]) begin
                w_rem_trial = w_acc_nxt[2*W-1:W-1];
                w_sum       = w_rem_trial - {1'b0, r_opnd};
                if (!w_sum[W]) begin
                    w_acc_nxt = {w_sum[W-1:0], w_acc_nxt[W-2:0], 1'b1};
                end else begin
                    w_acc_nxt = {w_rem_trial[W-1:0], w_acc_nxt[W-2:0], 1'b0};
                end
            end else begin
                w_sum     = {1'b0, w_acc_nxt[2*W-1:W]} +
                            (w_acc_nxt[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
                w_acc_nxt = {w_sum, w_acc_nxt[W-1:1]};
            end
        end
    end

    assign w_prod    = r_neg_res ? (~w_acc_nxt + (2*W)'(1)) : w_acc_nxt;
    assign w_quo     = w_acc_nxt[W-1:0];
    assign w_rem     = w_acc_nxt[2*W-1:W];
    assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
    assign w_div_res = r_op[1] ? (r_neg_a   ? (~w_rem + W'(1)) : w_rem)
                               : (r_neg_res ? (~w_quo + W'(1)) : w_quo);
    assign w_final   = r_op[2] ? w_div_res : w_mul_res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = w_special ? DONE : BUSY;
            BUSY: if (r_cnt == CNT_W'(N - 1)) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_a   <= 1'b0;
            r_neg_res <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            if (w_start) begin
                r_cnt     <= '0;
                r_op      <= MulDivOpE_i;
                r_neg_a   <= w_neg_a;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_opnd    <= MulDivOpE_i[2] ? w_mag_b : w_mag_a;
                r_acc     <= {{W{1'b0}}, (MulDivOpE_i[2] ? w_mag_a : w_mag_b)};
            end else if ((r_state == BUSY) && !flush_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_acc_nxt;
            end
            if ((w_state_nxt == DONE) && (r_state != DONE)) begin
                r_result <= (r_state == IDLE) ? w_special_res : w_final;
            end
        end
    end

    assign StallE_o    = rst_ni & validE_i & MulDivE_i & (r_state != DONE) & ~flush_i;
    assign DoneE_o     = (r_state == DONE);
    assign MDResultE_o = r_result;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed self-checking bench for execute_muldiv: arithmetic ops, special cases,
// forwarding capture, flush and mid-operation reset.
module tb_execute_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        validE_i;
    logic        MulDivE_i;
    logic [2:0]  MulDivOpE_i;
    logic [31:0] RD1E_i;
    logic [31:0] RD2E_i;
    logic [31:0] ResultW_i;
    logic [31:0] ALUResultM_i;
    logic [1:0]  ForwardAEctrl_i;
    logic [1:0]  ForwardBEctrl_i;
    logic        StallE_o;
    logic        DoneE_o;
    logic [31:0] MDResultE_o;

    int checks = 0;
    int errors = 0;

    execute_muldiv #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .validE_i       (validE_i),
        .MulDivE_i      (MulDivE_i),
        .MulDivOpE_i    (MulDivOpE_i),
        .RD1E_i         (RD1E_i),
        .RD2E_i         (RD2E_i),
        .ResultW_i      (ResultW_i),
        .ALUResultM_i   (ALUResultM_i),
        .ForwardAEctrl_i(ForwardAEctrl_i),
        .ForwardBEctrl_i(ForwardBEctrl_i),
        .StallE_o       (StallE_o),
        .DoneE_o        (DoneE_o),
        .MDResultE_o    (MDResultE_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, count stall cycles until DoneE_o, then check result and return to idle
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_stall, input bit perturb);
        int stalls = 0;
        int cyc    = 0;
        @(negedge clk_i);
        validE_i    = 1'b1;
        MulDivE_i   = 1'b1;
        MulDivOpE_i = op;
        RD1E_i      = a;
        RD2E_i      = b;
        #1;
        while (!DoneE_o && cyc < 200) begin
            if (StallE_o) stalls++;
            cyc++;
            @(negedge clk_i);
            if (perturb) begin
                ForwardAEctrl_i = 2'($urandom_range(0, 3));
                ForwardBEctrl_i = 2'($urandom_range(0, 3));
                RD1E_i          = $urandom;
                RD2E_i          = $urandom;
                ResultW_i       = $urandom;
                ALUResultM_i    = $urandom;
            end
            #1;
        end
        check({tag, " done_seen"}, 32'(cyc < 200), 32'd1);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, " stall_at_done"}, 32'(StallE_o), 32'd0);
        check({tag, " result"}, MDResultE_o, exp_res);
        validE_i        = 1'b0;
        MulDivE_i       = 1'b0;
        ForwardAEctrl_i = 2'b00;
        ForwardBEctrl_i = 2'b00;
        @(negedge clk_i);
        #1;
        check({tag, " idle_after"}, 32'(DoneE_o), 32'd0);
    endtask

    initial begin
        int dones;
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        validE_i        = 1'b1;
        MulDivE_i       = 1'b1;
        MulDivOpE_i     = 3'b000;
        RD1E_i          = 32'd0;
        RD2E_i          = 32'd0;
        ResultW_i       = 32'd0;
        ALUResultM_i    = 32'd0;
        ForwardAEctrl_i = 2'b00;
        ForwardBEctrl_i = 2'b00;

        repeat (2) @(negedge clk_i);
        #1;
        check("reset stall", 32'(StallE_o), 32'd0);
        check("reset done", 32'(DoneE_o), 32'd0);
        check("reset result", MDResultE_o, 32'd0);

        @(negedge clk_i);
        rst_ni    = 1'b1;
        validE_i  = 1'b1;
        MulDivE_i = 1'b0;
        #1;
        check("nonM stall", 32'(StallE_o), 32'd0);
        repeat (3) @(negedge clk_i);
        #1;
        check("nonM done", 32'(DoneE_o), 32'd0);
        validE_i = 1'b0;

        run_op("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        run_op("MULH min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run_op("MULHU",         3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run_op("MULHSU -1*max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
        run_op("MUL min*min",   3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 33, 1'b0);
        run_op("DIV 7/0",       3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        run_op("REM 7/0",       3'b110, 32'd7,        32'd0,        32'h00000007, 1,  1'b0);
        run_op("DIVU 7/0",      3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        run_op("REMU 7/0",      3'b111, 32'd7,        32'd0,        32'h00000007, 1,  1'b0);
        run_op("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        run_op("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0);
        run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
        run_op("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        run_op("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
        run_op("REMU 100/7",    3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);

        ALUResultM_i    = 32'd6;
        ResultW_i       = 32'd5;
        ForwardAEctrl_i = 2'b10;
        ForwardBEctrl_i = 2'b01;
        run_op("FWD MUL", 3'b000, 32'd100, 32'd200, 32'd30, 33, 1'b1);

        // Flush in BUSY cycle 10: no done pulse, result keeps 30
        @(negedge clk_i);
        validE_i    = 1'b1;
        MulDivE_i   = 1'b1;
        MulDivOpE_i = 3'b000;
        RD1E_i      = 32'd3;
        RD2E_i      = 32'd4;
        repeat (10) @(negedge clk_i);
        #1;
        check("flush pre stall", 32'(StallE_o), 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush stall", 32'(StallE_o), 32'd0);
        @(negedge clk_i);
        flush_i   = 1'b0;
        validE_i  = 1'b0;
        MulDivE_i = 1'b0;
        dones     = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (DoneE_o) dones++;
            @(negedge clk_i);
        end
        check("flush no done", 32'(dones), 32'd0);
        check("flush result kept", MDResultE_o, 32'd30);

        // Reset in BUSY cycle 5 clears everything immediately
        validE_i    = 1'b1;
        MulDivE_i   = 1'b1;
        MulDivOpE_i = 3'b000;
        RD1E_i      = 32'd9;
        RD2E_i      = 32'd9;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst stall", 32'(StallE_o), 32'd0);
        check("rst done", 32'(DoneE_o), 32'd0);
        check("rst result", MDResultE_o, 32'd0);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        validE_i  = 1'b0;
        MulDivE_i = 1'b0;
        run_op("post-rst MUL 9*9", 3'b000, 32'd9, 32'd9, 32'd81, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Parametrised RV32M execution unit that sits in the Execute stage beside the single-cycle ALU datapath.
- Resolves operand forwarding (Writeback and Memory sources) and captures operands when an M-extension op starts.
- Runs an iterative shift-add multiplier or restoring divider over several cycles.
- Holds the pipeline via a stall to the hazard unit until the result is ready.
- Presents the result on the same cycle the stall drops, so the Execute/Memory register captures it normally.

Parameters:
DATA_WIDTH, 32, operand/result width in bits.
BITS_PER_CYCLE, 1, multiplier/divider bits retired per iteration; must divide DATA_WIDTH.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  asynchronous active-low reset.
flush_i  input  1  Execute-stage flush (branch/jump redirect); aborts the current op.
validE_i  input  1  Execute stage holds a valid instruction.
MulDivE_i  input  1  instruction is an M-extension op.
MulDivOpE_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
RD1E_i  input  DATA_WIDTH  register-file rs1 value.
RD2E_i  input  DATA_WIDTH  register-file rs2 value.
ResultW_i  input  DATA_WIDTH  Writeback result for forwarding.
ALUResultM_i  input  DATA_WIDTH  Memory-stage ALU result for forwarding.
ForwardAEctrl_i  input  2  rs1 source: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
ForwardBEctrl_i  input  2  rs2 source, same encoding.
StallE_o  output  1  to hazard unit; freezes Fetch/Decode/Execute.
DoneE_o  output  1  one-cycle pulse; result valid this cycle.
MDResultE_o  output  DATA_WIDTH  M-extension result.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset drives IDLE, StallE_o=0, DoneE_o=0, MDResultE_o=0, and clears the iteration counter and all operand/accumulator registers.
- Start condition: state==IDLE & validE_i & MulDivE_i & !flush_i.
  - On start, latch the forwarded operands, the op, and the operand signs.
  - Operands are sampled only in the start cycle; later changes on the forwarding controls are ignored.
- Normal latency, N = DATA_WIDTH/BITS_PER_CYCLE:
  - Start cycle (IDLE): StallE_o=1.
  - N cycles in BUSY: StallE_o=1.
  - One cycle in DONE: StallE_o=0, DoneE_o=1, MDResultE_o valid.
  - Then IDLE. With defaults the stall lasts 33 cycles and the result appears in the 34th cycle.
- StallE_o is combinational: validE_i & MulDivE_i & state!=DONE & !flush_i.
- The result register holds its last value after DONE; it is updated only on the transition into DONE.
- Multiply:
  - Iterate on magnitudes; MULH/MULHSU treat rs1 as signed, MULHSU treats rs2 as unsigned, MULHU treats both as unsigned.
  - Negate the 2*DATA_WIDTH product when the operand signs differ.
  - MUL returns the low half; the others return the high half.
- Divide:
  - Restoring, on magnitudes for DIV/REM and raw values for DIVU/REMU.
  - Quotient is negated if operand signs differ; remainder takes the dividend's sign.
- Special cases: detected at start; state goes IDLE->DONE directly with no BUSY cycles (stall for 1 cycle only).
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (most-negative / -1): DIV returns the most-negative value; REM returns 0.
- Flush: flush_i in any state returns to IDLE next cycle. No DoneE_o, MDResultE_o unchanged, StallE_o forced 0 in that cycle.
- Non-M instruction (MulDivE_i=0) or validE_i=0 in IDLE: no start, StallE_o=0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no pending result survives.
- In DONE the next cycle is always IDLE, even if another M op follows; that op starts from IDLE (back-to-back ops incur no extra bubble beyond the normal stall).

Test Plan:
- MUL, RD1E=7, RD2E=0xFFFFFFFD, forwarding 00/00 -> StallE_o high for 33 cycles, then DoneE_o=1 with MDResultE_o=0xFFFFFFEB; IDLE on the following cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 0x00000007, each with 1 stall cycle then DONE; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 and REMU 100/7 -> 2.
- Forwarding: ForwardAEctrl=10 with ALUResultM=6, ForwardBEctrl=01 with ResultW=5, MUL -> 30. Change both controls and sources during BUSY -> result still 30.
- Flush at BUSY cycle 10 -> IDLE next cycle, no DoneE_o pulse, MDResultE_o retains the prior value. rst_ni low at BUSY cycle 5 -> all outputs 0 immediately, and a new op after release completes normally.
